// File: rtl/m1_round_feed_if.sv
// Bus between the SHA-256 round sequencer and the external a..h shift-register pair
// together with its W/K word sources.
interface m1_round_feed_if;
    logic         start;
    logic [255:0] iv_in;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  c;
    logic [31:0]  d;
    logic [31:0]  e;
    logic [31:0]  f;
    logic [31:0]  g;
    logic [31:0]  h;
    logic [31:0]  w_in;
    logic [31:0]  k_in;
    logic [5:0]   round_idx;
    logic [31:0]  abc_data_out;
    logic [31:0]  e_data_out;
    logic         abc_en;
    logic         busy;
    logic         done;

    modport master (
        output start, iv_in, a, b, c, d, e, f, g, h, w_in, k_in,
        input  round_idx, abc_data_out, e_data_out, abc_en, busy, done
    );

    modport slave (
        input  start, iv_in, a, b, c, d, e, f, g, h, w_in, k_in,
        output round_idx, abc_data_out, e_data_out, abc_en, busy, done
    );
endinterface

// File: rtl/m1_round_feed.sv
// SHA-256 compression round sequencer: loads the IV into the external a..h chains,
// then runs 64 two-cycle rounds (evaluate, shift) and pulses done.
module m1_round_feed (
    input  logic           clk_h,
    input  logic           rst_n,
    m1_round_feed_if.slave bus
);
    localparam int DATA_W   = 32;
    localparam int LAST_RND = 63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_R_EVAL,
        S_R_SHIFT,
        S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] big_sigma0(input logic [DATA_W-1:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [DATA_W-1:0] big_sigma1(input logic [DATA_W-1:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [DATA_W-1:0] choose(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic [DATA_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [DATA_W-1:0] majority(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [DATA_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_load_cnt;
    logic [1:0]          w_load_cnt_nxt;
    logic [1:0]          w_load_inc;
    logic [255:0]        r_iv;
    logic [255:0]        w_iv_nxt;
    logic [DATA_W-1:0]   w_iv_words [8];
    logic [5:0]          r_round_idx;
    logic [5:0]          w_round_idx_nxt;
    logic [DATA_W-1:0]   w_t1_p0;
    logic [DATA_W-1:0]   w_t2_p0;
    logic [DATA_W-1:0]   r_abc_data_p1;
    logic [DATA_W-1:0]   w_abc_data_nxt;
    logic [DATA_W-1:0]   r_e_data_p1;
    logic [DATA_W-1:0]   w_e_data_nxt;
    logic                r_abc_en;
    logic                w_abc_en_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    // Stage 0: round arithmetic on the working variables read back this cycle
    assign w_t1_p0 = bus.h + big_sigma1(bus.e) + choose(bus.e, bus.f, bus.g)
                   + bus.k_in + bus.w_in;
    assign w_t2_p0 = big_sigma0(bus.a) + majority(bus.a, bus.b, bus.c);

    // Word i of the latched IV, i=0 is a ... i=7 is h
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_iv_words[i] = r_iv[255 - 32*i -: 32];
        end
    end

    // Load step n shifts d,c,b,a / h,g,f,e, i.e. word indices 3-n and 7-n
    assign w_load_inc = r_load_cnt + 2'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_load_cnt_nxt  = r_load_cnt;
        w_iv_nxt        = r_iv;
        w_round_idx_nxt = r_round_idx;
        w_abc_data_nxt  = r_abc_data_p1;
        w_e_data_nxt    = r_e_data_p1;
        w_abc_en_nxt    = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_round_idx_nxt = 6'd0;
                w_busy_nxt      = 1'b0;
                if (bus.start) begin
                    w_state_nxt    = S_INIT;
                    w_load_cnt_nxt = 2'd0;
                    w_iv_nxt       = bus.iv_in;
                    w_abc_data_nxt = bus.iv_in[159:128];
                    w_e_data_nxt   = bus.iv_in[31:0];
                    w_abc_en_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end

            S_INIT: begin
                if (r_load_cnt == 2'd3) begin
                    w_state_nxt     = S_R_EVAL;
                    w_round_idx_nxt = 6'd0;
                end else begin
                    w_load_cnt_nxt = w_load_inc;
                    w_abc_data_nxt = w_iv_words[{1'b0, ~w_load_inc}];
                    w_e_data_nxt   = w_iv_words[{1'b1, ~w_load_inc}];
                    w_abc_en_nxt   = 1'b1;
                end
            end

            S_R_EVAL: begin
                w_abc_data_nxt = w_t1_p0 + w_t2_p0;
                w_e_data_nxt   = bus.d + w_t1_p0;
                w_abc_en_nxt   = 1'b1;
                w_state_nxt    = S_R_SHIFT;
            end

            S_R_SHIFT: begin
                if (r_round_idx != 6'(LAST_RND)) begin
                    w_round_idx_nxt = r_round_idx + 6'd1;
                    w_state_nxt     = S_R_EVAL;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end

            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_round_idx_nxt = 6'd0;
                w_busy_nxt      = 1'b0;
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_round_idx_nxt = 6'd0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_load_cnt    <= 2'd0;
            r_round_idx   <= 6'd0;
            r_abc_data_p1 <= '0;
            r_e_data_p1   <= '0;
            r_abc_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_cnt    <= w_load_cnt_nxt;
            r_round_idx   <= w_round_idx_nxt;
            r_abc_data_p1 <= w_abc_data_nxt;
            r_e_data_p1   <= w_e_data_nxt;
            r_abc_en      <= w_abc_en_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // The IV copy is pure data and is always reloaded at start accept
    always_ff @(posedge clk_h) begin
        r_iv <= w_iv_nxt;
    end

    assign bus.round_idx    = r_round_idx;
    assign bus.abc_data_out = r_abc_data_p1;
    assign bus.e_data_out   = r_e_data_p1;
    assign bus.abc_en       = r_abc_en;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_m1_round_feed.sv
// Directed bench for m1_round_feed: behavioural a..h shift registers, FIPS-180 "abc"
// message schedule and round constants, hand-computed expected values.
module tb_m1_round_feed;
    localparam logic [255:0] IV_ABC =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIGEST_ABC =
        256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk_h = 1'b0;
    logic        rst_n;
    bit          force_ones;
    logic [31:0] w_sched [64];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    m1_round_feed_if bus ();

    m1_round_feed dut (
        .clk_h (clk_h),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_h = ~clk_h;

    // External abc/efgh chain pair
    always @(posedge clk_h) begin
        if (bus.abc_en) begin
            bus.a <= bus.abc_data_out;
            bus.b <= bus.a;
            bus.c <= bus.b;
            bus.d <= bus.c;
            bus.e <= bus.e_data_out;
            bus.f <= bus.e;
            bus.g <= bus.f;
            bus.h <= bus.g;
        end
    end

    assign bus.w_in = force_ones ? 32'hffffffff : w_sched[bus.round_idx];
    assign bus.k_in = force_ones ? 32'hffffffff : K_TAB[bus.round_idx];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge in IDLE; returns at the negedge of the first INIT cycle.
    task automatic accept(input logic [255:0] iv);
        bus.iv_in = iv;
        bus.start = 1'b1;
        @(negedge clk_h);
        bus.start = 1'b0;
        bus.iv_in = '0;
    endtask

    // Sample k=1 is the first INIT cycle; returns at the negedge of the done cycle
    // (or after the cycle budget) with start driven to pulse_done.
    task automatic run_to_done(input int pulse_round, input bit pulse_done,
                               output int done_k, output int en_cnt,
                               output logic [31:0] abc6, output logic [31:0] e6);
        bit pulsed;
        pulsed = 1'b0;
        done_k = 0;
        en_cnt = 0;
        abc6   = '0;
        e6     = '0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            if (k > 1) begin
                @(negedge clk_h);
                bus.start = 1'b0;
            end
            if (bus.abc_en) en_cnt++;
            if (k == 6) begin
                abc6 = bus.abc_data_out;
                e6   = bus.e_data_out;
            end
            if (bus.done) begin
                done_k    = k;
                bus.start = pulse_done;
                chk("done_cycle_abc_en", 256'(bus.abc_en), 256'd0);
                chk("done_cycle_busy", 256'(bus.busy), 256'd0);
                chk("done_cycle_round_idx", 256'(bus.round_idx), 256'd63);
            end else if (!pulsed && int'(bus.round_idx) == pulse_round) begin
                bus.start = 1'b1;
                pulsed    = 1'b1;
            end
        end
    endtask

    initial begin
        int          done_k;
        int          en_cnt;
        logic [31:0] abc6;
        logic [31:0] e6;
        logic [71:0] idle_acc;
        logic        idle_en;

        rst_n      = 1'b0;
        force_ones = 1'b0;
        bus.start  = 1'b0;
        bus.iv_in  = '0;
        for (int t = 0; t < 16; t++) w_sched[t] = 32'h0;
        w_sched[0]  = 32'h61626380;
        w_sched[15] = 32'h00000018;
        for (int t = 16; t < 64; t++) begin
            w_sched[t] = (rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                       + w_sched[t-7]
                       + (rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                       + w_sched[t-16];
        end

        // Reset and idle
        repeat (3) @(negedge clk_h);
        rst_n = 1'b1;
        chk("rst_round_idx", 256'(bus.round_idx), 256'd0);
        chk("rst_abc_data", 256'(bus.abc_data_out), 256'd0);
        chk("rst_e_data", 256'(bus.e_data_out), 256'd0);
        chk("rst_abc_en", 256'(bus.abc_en), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_done", 256'(bus.done), 256'd0);
        idle_acc = '0;
        idle_en  = 1'b0;
        repeat (10) begin
            @(negedge clk_h);
            idle_acc |= {bus.round_idx, bus.abc_data_out, bus.e_data_out, bus.busy, bus.done};
            idle_en  |= bus.abc_en;
        end
        chk("idle_outputs", 256'(idle_acc), 256'd0);
        chk("idle_abc_en", 256'(idle_en), 256'd0);

        // Block 1: "abc", start pulsed at round 10 and in the DONE cycle
        accept(IV_ABC);
        chk("init0_busy", 256'(bus.busy), 256'd1);
        chk("init0_abc_en", 256'(bus.abc_en), 256'd1);
        chk("init0_abc_word_d", 256'(bus.abc_data_out), 256'h a54ff53a);
        chk("init0_e_word_h", 256'(bus.e_data_out), 256'h 5be0cd19);
        run_to_done(10, 1'b1, done_k, en_cnt, abc6, e6);
        chk("shift0_abc_data", 256'(abc6), 256'h 5d6aebcd);
        chk("shift0_e_data", 256'(e6), 256'h fa2a4622);
        chk("done_latency", 256'(done_k), 256'd133);
        chk("abc_en_count", 256'(en_cnt), 256'd68);
        chk("digest_state", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h}, DIGEST_ABC);
        @(negedge clk_h);
        bus.start = 1'b0;
        chk("idle_after_done_busy", 256'(bus.busy), 256'd0);
        chk("idle_after_done_round_idx", 256'(bus.round_idx), 256'd0);
        chk("idle_after_done_done", 256'(bus.done), 256'd0);
        @(negedge clk_h);
        chk("done_start_not_taken", 256'(bus.busy), 256'd0);
        chk("done_start_no_abc_en", 256'(bus.abc_en), 256'd0);

        // Block 2: reset at round 40, then a clean rerun
        accept(IV_ABC);
        for (int k = 0; k < 300 && bus.round_idx != 6'd40; k++) @(negedge clk_h);
        chk("reach_round40", 256'(bus.round_idx), 256'd40);
        chk("round40_busy", 256'(bus.busy), 256'd1);
        rst_n = 1'b0;
        @(negedge clk_h);
        rst_n = 1'b1;
        chk("midrst_round_idx", 256'(bus.round_idx), 256'd0);
        chk("midrst_abc_data", 256'(bus.abc_data_out), 256'd0);
        chk("midrst_e_data", 256'(bus.e_data_out), 256'd0);
        chk("midrst_abc_en", 256'(bus.abc_en), 256'd0);
        chk("midrst_busy", 256'(bus.busy), 256'd0);
        chk("midrst_done", 256'(bus.done), 256'd0);
        accept(IV_ABC);
        run_to_done(-1, 1'b0, done_k, en_cnt, abc6, e6);
        chk("rerun_done_latency", 256'(done_k), 256'd133);
        chk("rerun_abc_en_count", 256'(en_cnt), 256'd68);
        chk("rerun_digest_state", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h}, DIGEST_ABC);
        @(negedge clk_h);

        // Block 3: all-ones state, W and K -- modulo 2^32 wrap
        force_ones = 1'b1;
        accept({256{1'b1}});
        repeat (5) @(negedge clk_h);
        chk("ones_r0_abc_data", 256'(bus.abc_data_out), 256'h fffffff9);
        chk("ones_r0_e_data", 256'(bus.e_data_out), 256'h fffffffa);
        chk("ones_r0_abc_en", 256'(bus.abc_en), 256'd1);
        repeat (2) @(negedge clk_h);
        chk("ones_r1_round_idx", 256'(bus.round_idx), 256'd1);
        chk("ones_r1_abc_data", 256'(bus.abc_data_out), 256'h 6b2fe578);
        chk("ones_r1_e_data", 256'(bus.e_data_out), 256'h eb5ffd7a);
        rst_n = 1'b0;
        @(negedge clk_h);
        rst_n      = 1'b1;
        force_ones = 1'b0;
        chk("final_rst_busy", 256'(bus.busy), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
